// File: rtl/load_align_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit_if
// Purpose  : Request / data-memory / response bundle for load_align_unit.
//            slave  = the load unit itself, master = its environment.
// Revision : 1.0  initial release
// ============================================================================
interface load_align_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  // Load request from execute stage
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [AWIDTH-1:0] req_addr;
  // Data-memory read port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;
  // Load result
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_data;
  logic              rsp_fault;

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_req_ready, mem_rvalid,
           mem_rdata, rsp_ready,
    output req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );

  modport master (
    output req_valid, req_funct3, req_addr, mem_req_ready, mem_rvalid,
           mem_rdata, rsp_ready,
    input  req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit
// Purpose  : Multi-cycle load path. Issues word-aligned reads, extracts the
//            addressed bytes from one or two words and sign/zero-extends them.
//            Optional macro LOAD_ALIGN_MISALIGNED_EN: when defined, loads that
//            cross a word boundary are served with two reads; when undefined,
//            any access whose offset is not a multiple of its size faults.
// Revision : 1.0  initial release
// ============================================================================
module load_align_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  load_align_unit_if.slave  lsu
);

  localparam int NB = DWIDTH / 8;            // bytes per word
  localparam int OW = $clog2(NB);            // byte-offset width
  localparam int SW = $clog2(2 * DWIDTH);    // bit-index width into {hi,lo}
  localparam logic [AWIDTH-1:0] C_STEP = AWIDTH'(NB);

`ifdef LOAD_ALIGN_MISALIGNED_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    RESP  = 3'd5
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q,  addr_d;
  logic [2:0]        f3_q,    f3_d;
  logic [DWIDTH-1:0] data_q,  data_d;
  logic              fault_q, fault_d;
`ifdef LOAD_ALIGN_MISALIGNED_EN
  logic [DWIDTH-1:0] lo_q,    lo_d;          // first (lower) word of a span
`endif

  // funct3 decoding: ld and lwu only exist on a 64-bit datapath
  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: is_legal = 1'b1;
      3'd3, 3'd6:                   is_legal = (DWIDTH == 64);
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

`ifdef LOAD_ALIGN_MISALIGNED_EN
  function automatic logic is_spanning(input logic [2:0] f3, input logic [OW-1:0] off);
    return (5'(off) + 5'(size_of(f3))) > 5'(NB);
  endfunction
`else
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [OW-1:0] off);
    return (4'(off) & (size_of(f3) - 4'd1)) != 4'd0;
  endfunction
`endif

  // Shift {hi,lo} down to the addressed byte, keep 8*S bits, then extend.
  // A full-width access gets an all-zero fill mask, so sign never matters.
  function automatic logic [DWIDTH-1:0] extract(input logic [2:0]          f3,
                                                input logic [OW-1:0]       off,
                                                input logic [2*DWIDTH-1:0] pair);
    logic [2*DWIDTH-1:0] sh;
    logic [DWIDTH-1:0]   mask;
    logic [DWIDTH-1:0]   val;
    logic [6:0]          nbits;
    logic                sbit;
    sh    = pair >> {off, 3'b000};
    nbits = 7'd8 << f3[1:0];
    mask  = (DWIDTH'(1) << nbits) - DWIDTH'(1);
    val   = sh[DWIDTH-1:0] & mask;
    sbit  = sh[SW'(nbits - 7'd1)];
    if (!f3[2] && sbit) begin
      val = val | ~mask;
    end
    return val;
  endfunction

  logic [OW-1:0]     w_off_q;
  logic [AWIDTH-1:0] w_base;
  logic              w_req_fault;

  assign w_off_q = addr_q[OW-1:0];
  assign w_base  = {addr_q[AWIDTH-1:OW], {OW{1'b0}}};

`ifdef LOAD_ALIGN_MISALIGNED_EN
  assign w_req_fault = !is_legal(lsu.req_funct3);
`else
  assign w_req_fault = !is_legal(lsu.req_funct3) ||
                       is_misaligned(lsu.req_funct3, lsu.req_addr[OW-1:0]);
`endif

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
`ifdef LOAD_ALIGN_MISALIGNED_EN
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      data_q  <= data_d;
      fault_q <= fault_d;
`ifdef LOAD_ALIGN_MISALIGNED_EN
      lo_q    <= lo_d;
`endif
    end
  end

  // Next-state and outputs; outputs depend only on registered state so
  // mem_addr and rsp_* hold steady while their handshakes are pending
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    f3_d              = f3_q;
    data_d            = data_q;
    fault_d           = fault_q;
`ifdef LOAD_ALIGN_MISALIGNED_EN
    lo_d              = lo_q;
`endif
    lsu.req_ready     = 1'b0;
    lsu.mem_req_valid = 1'b0;
    lsu.mem_addr      = '0;
    lsu.rsp_valid     = 1'b0;
    lsu.rsp_data      = '0;
    lsu.rsp_fault     = 1'b0;

    case (state_q)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          addr_d = lsu.req_addr;
          f3_d   = lsu.req_funct3;
          if (w_req_fault) begin
            data_d  = '0;
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d = 1'b0;
            state_d = REQ0;
          end
        end
      end

      REQ0: begin
        lsu.mem_req_valid = 1'b1;
        lsu.mem_addr      = w_base;
        if (lsu.mem_req_ready) begin
          state_d = WAIT0;
        end
      end

      WAIT0: begin
        if (lsu.mem_rvalid) begin
`ifdef LOAD_ALIGN_MISALIGNED_EN
          lo_d = lsu.mem_rdata;
          if (is_spanning(f3_q, w_off_q)) begin
            state_d = REQ1;
          end else begin
            data_d  = extract(f3_q, w_off_q, {{DWIDTH{1'b0}}, lsu.mem_rdata});
            state_d = RESP;
          end
`else
          data_d  = extract(f3_q, w_off_q, {{DWIDTH{1'b0}}, lsu.mem_rdata});
          state_d = RESP;
`endif
        end
      end

`ifdef LOAD_ALIGN_MISALIGNED_EN
      REQ1: begin
        lsu.mem_req_valid = 1'b1;
        lsu.mem_addr      = w_base + C_STEP;
        if (lsu.mem_req_ready) begin
          state_d = WAIT1;
        end
      end

      WAIT1: begin
        if (lsu.mem_rvalid) begin
          data_d  = extract(f3_q, w_off_q, {lsu.mem_rdata, lo_q});
          state_d = RESP;
        end
      end
`endif

      RESP: begin
        lsu.rsp_valid = 1'b1;
        lsu.rsp_data  = data_q;
        lsu.rsp_fault = fault_q;
        if (lsu.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_align_unit
// Purpose  : Self-checking bench: a byte-level load model and scoreboard for a
//            32-bit unit plus directed checks on a 64-bit unit. Follows the
//            LOAD_ALIGN_MISALIGNED_EN setting of the build.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_align_unit_if #(.DWIDTH(32), .AWIDTH(32)) i32 ();
  load_align_unit_if #(.DWIDTH(64), .AWIDTH(32)) i64 ();

  load_align_unit #(.DWIDTH(32), .AWIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .lsu(i32));
  load_align_unit #(.DWIDTH(64), .AWIDTH(32)) u_dut64 (.clk(clk), .rst(rst), .lsu(i64));

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] mem [0:255];      // 32-bit memory image, word index = addr[9:2]
  bit          stray = 1'b0;     // inject mem_rvalid with no read outstanding
  bit          mute  = 1'b0;     // swallow read responses
  logic [63:0] word64 = '0;      // data returned by the 64-bit memory

  typedef struct {
    logic [31:0] d;
    bit          f;
    int          n;              // number of memory reads expected
    logic [31:0] base;           // aligned address of first read
  } exp_t;

  exp_t q[$];
  int   nseen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return 8'(w >> {a[1:0], 3'b000});
  endfunction

  // Expected result built byte by byte from the memory image (little endian)
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a);
    exp_t        e;
    int          sz;
    int          off;
    bit          legal;
    bit          bad;
    logic [31:0] v;
    sz     = 1 << f3[1:0];
    off    = int'(a[1:0]);
    legal  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LOAD_ALIGN_MISALIGNED_EN
    bad    = !legal;
`else
    bad    = !legal || ((off % sz) != 0);
`endif
    e.base = {a[31:2], 2'b00};
    if (bad) begin
      e.d = '0; e.f = 1'b1; e.n = 0;
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      e.d = v; e.f = 1'b0; e.n = ((off + sz) > 4) ? 2 : 1;
    end
    return e;
  endfunction

  // 32-bit memory responder: rvalid one cycle after each read handshake
  initial begin
    bit          hs, inj, mu;
    logic [31:0] ha;
    i32.mem_rvalid = 1'b0;
    i32.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = i32.mem_req_valid && i32.mem_req_ready;
      ha = i32.mem_addr;
      inj = stray;
      mu  = mute;
      @(posedge clk); #1;
      i32.mem_rvalid = (hs && !mu) || inj;
      i32.mem_rdata  = hs ? mem[ha[9:2]] : 32'hDEAD_BEEF;
    end
  end

  // 64-bit memory responder: always returns word64
  initial begin
    bit hs;
    i64.mem_rvalid = 1'b0;
    i64.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = i64.mem_req_valid && i64.mem_req_ready;
      @(posedge clk); #1;
      i64.mem_rvalid = hs;
      i64.mem_rdata  = word64;
    end
  end

  // Scoreboard / protocol compare for the 32-bit unit, every cycle
  initial begin
    bit          p_mv = 0, p_mr = 0, p_rv = 0, p_rr = 0, p_rf = 0;
    logic [31:0] p_ma = '0, p_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        nseen = 0;
        p_mv = 0; p_rv = 0;
      end else begin
        chk("req_ready_vs_busy", 64'(i32.req_ready), 64'(q.size() == 0));
        if (i32.mem_req_valid) chk("mem_addr_aligned", 64'(i32.mem_addr[1:0]), 64'd0);
        if (i32.mem_req_valid && p_mv && !p_mr) chk("mem_addr_stable", 64'(i32.mem_addr), 64'(p_ma));
        if (i32.rsp_valid && p_rv && !p_rr) begin
          chk("rsp_data_stable", 64'(i32.rsp_data), 64'(p_rd));
          chk("rsp_fault_stable", 64'(i32.rsp_fault), 64'(p_rf));
        end
        if (i32.mem_req_valid && i32.mem_req_ready) begin
          if (q.size() == 0) timeout("mem_req_without_load");
          else begin
            chk("mem_addr", 64'(i32.mem_addr), 64'(q[0].base + 32'(4 * nseen)));
            nseen++;
          end
        end
        if (i32.rsp_valid) begin
          if (q.size() == 0) timeout("rsp_without_load");
          else begin
            chk("rsp_data", 64'(i32.rsp_data), 64'(q[0].d));
            chk("rsp_fault", 64'(i32.rsp_fault), 64'(q[0].f));
            if (i32.rsp_ready) begin
              chk("mem_read_count", 64'(nseen), 64'(q[0].n));
              void'(q.pop_front());
              nseen = 0;
            end
          end
        end
        if (i32.req_valid && i32.req_ready) q.push_back(model(i32.req_funct3, i32.req_addr));
        p_mv = i32.mem_req_valid; p_mr = i32.mem_req_ready; p_ma = i32.mem_addr;
        p_rv = i32.rsp_valid;     p_rr = i32.rsp_ready;
        p_rd = i32.rsp_data;      p_rf = i32.rsp_fault;
      end
    end
  end

  // One load on the 32-bit unit; starts #1 after an edge, ends #1 after the
  // response handshake edge. lat counts cycles from acceptance to rsp_valid.
  task automatic load32(input logic [2:0] f3, input logic [31:0] a, input int rstall,
                        output logic [31:0] d, output bit f, output int lat, output int accw);
    i32.rsp_ready  = (rstall == 0);
    i32.req_valid  = 1'b1;
    i32.req_funct3 = f3;
    i32.req_addr   = a;
    accw = 0;
    while (!i32.req_ready && accw < 50) begin @(posedge clk); #1; accw++; end
    if (!i32.req_ready) timeout("accept");
    @(posedge clk); #1;
    i32.req_valid = 1'b0;
    lat = 1;
    while (!i32.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!i32.rsp_valid) timeout("response");
    d = i32.rsp_data;
    f = i32.rsp_fault;
    if (rstall > 0) begin
      repeat (rstall) begin @(posedge clk); #1; end
      i32.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic load64(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] w,
                        output logic [63:0] d, output bit f);
    int k;
    word64 = w;
    chk("r64_req_ready", 64'(i64.req_ready), 64'd1);
    i64.req_valid  = 1'b1;
    i64.req_funct3 = f3;
    i64.req_addr   = a;
    @(posedge clk); #1;
    i64.req_valid = 1'b0;
    k = 0;
    while (!i64.rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    if (!i64.rsp_valid) timeout("r64_response");
    d = i64.rsp_data;
    f = i64.rsp_fault;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [63:0] d64;
    bit          f;
    int          lat, aw;

    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
    rst = 1'b1;
    i32.req_valid = 1'b0; i32.req_funct3 = '0; i32.req_addr = '0;
    i32.mem_req_ready = 1'b1; i32.rsp_ready = 1'b1;
    i64.req_valid = 1'b0; i64.req_funct3 = '0; i64.req_addr = '0;
    i64.mem_req_ready = 1'b1; i64.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_req_ready", 64'(i32.req_ready), 64'd1);
    chk("rst_mem_req_valid", 64'(i32.mem_req_valid), 64'd0);
    chk("rst_mem_addr", 64'(i32.mem_addr), 64'd0);
    chk("rst_rsp_valid", 64'(i32.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(i32.rsp_data), 64'd0);
    chk("rst_rsp_fault", 64'(i32.rsp_fault), 64'd0);

    // lb sign extension and T+3 latency
    mem[8'h40] = 32'h80FF_1234;
    load32(3'd0, 32'h103, 0, d, f, lat, aw);
    chk("lb_data", 64'(d), 64'hFFFF_FF80);
    chk("lb_fault", 64'(f), 64'd0);
    chk("lb_latency", 64'(lat), 64'd3);
    load32(3'd4, 32'h101, 0, d, f, lat, aw);       // lbu -> 0x12
    chk("lbu_data", 64'(d), 64'h0000_0012);
    load32(3'd2, 32'h100, 0, d, f, lat, aw);       // aligned lw
    chk("lw_data", 64'(d), 64'h80FF_1234);

    // Halfwords, issued back to back
    mem[8'h40] = 32'hBEEF_0000;
    load32(3'd5, 32'h102, 0, d, f, lat, aw);
    chk("lhu_data", 64'(d), 64'h0000_BEEF);
    load32(3'd1, 32'h102, 0, d, f, lat, aw);
    chk("lh_data", 64'(d), 64'hFFFF_BEEF);
    chk("back_to_back_accept", 64'(aw), 64'd0);

    // Word spanning two memory words
    mem[8'h3F] = 32'h1122_3344;
    mem[8'h40] = 32'hAABB_CCDD;
    load32(3'd2, 32'h0FE, 0, d, f, lat, aw);
`ifdef LOAD_ALIGN_MISALIGNED_EN
    chk("span_lw_data", 64'(d), 64'hCCDD_1122);
    chk("span_lw_fault", 64'(f), 64'd0);
    chk("span_lw_latency", 64'(lat), 64'd5);
`else
    chk("span_lw_data", 64'(d), 64'd0);
    chk("span_lw_fault", 64'(f), 64'd1);
    chk("span_lw_latency", 64'(lat), 64'd1);
`endif
    load32(3'd5, 32'h101, 0, d, f, lat, aw);       // unaligned, non-spanning

    // Illegal funct3 on a 32-bit datapath
    load32(3'd3, 32'h100, 0, d, f, lat, aw);
    chk("ld32_fault", 64'(f), 64'd1);
    chk("ld32_data", 64'(d), 64'd0);
    chk("ld32_latency", 64'(lat), 64'd1);
    load32(3'd7, 32'h104, 0, d, f, lat, aw);
    chk("f3_7_fault", 64'(f), 64'd1);

    // Memory stalls 5 cycles, consumer stalls 3 cycles
    mem[8'h40] = 32'h80FF_1234;
    i32.mem_req_ready = 1'b0;
    fork
      load32(3'd2, 32'h100, 3, d, f, lat, aw);
      begin repeat (6) @(posedge clk); #1; i32.mem_req_ready = 1'b1; end
    join
    chk("stall_lw_data", 64'(d), 64'h80FF_1234);
    chk("stall_lw_latency", 64'(lat), 64'd8);

    // Reset while waiting for read data, then a stray rvalid
    mute = 1'b1;
    i32.req_valid = 1'b1; i32.req_funct3 = 3'd0; i32.req_addr = 32'h100;
    @(posedge clk); #1;
    i32.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("wait0_no_mem_req", 64'(i32.mem_req_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mute = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) stray = 1'b0;
      chk("abort_rsp_valid", 64'(i32.rsp_valid), 64'd0);
      chk("abort_req_ready", 64'(i32.req_ready), 64'd1);
      @(posedge clk); #1;
    end
    load32(3'd0, 32'h103, 0, d, f, lat, aw);
    chk("post_rst_lb", 64'(d), 64'hFFFF_FF80);
    chk("post_rst_latency", 64'(lat), 64'd3);

    // 64-bit datapath
    load64(3'd6, 32'h10, 64'h0000_0000_FFFF_FFFF, d64, f);
    chk("lwu64_data", d64, 64'h0000_0000_FFFF_FFFF);
    chk("lwu64_fault", 64'(f), 64'd0);
    load64(3'd2, 32'h10, 64'h0000_0000_FFFF_FFFF, d64, f);
    chk("lw64_data", d64, 64'hFFFF_FFFF_FFFF_FFFF);
    load64(3'd3, 32'h18, 64'h8000_0000_0000_0001, d64, f);
    chk("ld64_data", d64, 64'h8000_0000_0000_0001);
    load64(3'd6, 32'h14, 64'hFFFF_FFFF_0000_0000, d64, f);
    chk("lwu64_hi_data", d64, 64'h0000_0000_FFFF_FFFF);
    load64(3'd0, 32'h17, 64'h8000_0000_0000_0000, d64, f);
    chk("lb64_data", d64, 64'hFFFF_FFFF_FFFF_FF80);
    load64(3'd7, 32'h10, 64'h1234_5678_9ABC_DEF0, d64, f);
    chk("f3_7_64_fault", 64'(f), 64'd1);
    chk("f3_7_64_data", d64, 64'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_align_unit.md
# load_align_unit

Load-path unit that accepts byte/half/word(/double) load requests at arbitrary byte addresses and issues word-aligned reads to data memory. It extracts the addressed bytes from one or two returned words, sign- or zero-extends them per funct3, and returns the result through a valid/ready handshake. It sits between the execute stage and the data-memory port, replacing purely combinational extension with an aligned, optionally misaligned-capable, multi-cycle load path.

## Interface
- DWIDTH, 32, data/word width; legal values 32 or 64.
- AWIDTH, 32, byte-address width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  RISC-V load funct3.
- req_addr  in  AWIDTH  byte address.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts read.
- mem_addr  out  AWIDTH  word-aligned read address (low log2(DWIDTH/8) bits zero).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DWIDTH  read data.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DWIDTH  extended load result.
- rsp_fault  out  1  request faulted; qualified by rsp_valid.

## Operation
- Legal funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; with DWIDTH=64 also 3 ld, 6 lwu. Any other value is illegal.
- Size S bytes (1/2/4/8); offset O = req_addr mod (DWIDTH/8); spanning when O+S > DWIDTH/8.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/funct3. Illegal funct3 or disallowed misalignment -> RESP with fault. Otherwise -> REQ0.
- REQ0: mem_req_valid=1, mem_addr = aligned addr. On mem_req_ready -> WAIT0.
- WAIT0: on mem_rvalid, capture low word. Spanning -> REQ1, else -> RESP.
- REQ1: mem_addr = aligned addr + DWIDTH/8, wrapping modulo 2^AWIDTH. On mem_req_ready -> WAIT1.
- WAIT1: on mem_rvalid, capture high word -> RESP.
- RESP: rsp_valid=1, outputs held stable. On rsp_ready -> IDLE.
- Extraction: form {high,low} (high=0 if not spanning), shift right by 8*O, keep low 8*S bits. Signed ops replicate bit 8*S-1; unsigned ops and ld/lw-at-full-width zero-fill.
- Fault response: rsp_data=0, rsp_fault=1, no memory access issued.
- mem_rvalid outside WAIT0/WAIT1 is ignored. Only one read is outstanding at any time.

## Timing
- Reset: state=IDLE. req_ready=1, mem_req_valid=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_fault=0.
- Reset mid-operation aborts the transaction. Any later mem_rvalid for it is ignored.
- Non-spanning, memory ready and 1-cycle read: accept at T, mem_req at T+1, rvalid at T+2, rsp_valid at T+3.
- Spanning adds 2 cycles minimum. Fault: rsp_valid at T+1.
- Back-to-back: a new request is accepted the cycle after the RESP handshake.
- mem_req_valid and mem_addr stay stable until mem_req_ready. rsp_* stays stable until rsp_ready.

## Configuration
- LOAD_ALIGN_MISALIGNED_EN defined: spanning loads execute via two reads (REQ1/WAIT1 present).
- Not defined: any spanning load, and any access with O not a multiple of S, returns rsp_fault=1 without a memory access. REQ1/WAIT1 are not built. Non-spanning unaligned accesses also fault.

## Test plan
- DWIDTH=32, lb addr 0x103, word 0x80FF_1234 -> rsp_data 0xFFFF_FF80, fault 0, rsp_valid at T+3.
- lhu addr 0x102, word 0xBEEF_0000 -> 0x0000_BEEF. lh same -> 0xFFFF_BEEF.
- Macro on, lw addr 0x0FE, words 0x1122_3344 @0x0FC and 0xAABB_CCDD @0x100 -> two reads, rsp_data 0xCCDD_1122. Macro off -> fault=1, data 0, no mem_req_valid.
- funct3=3 with DWIDTH=32 -> fault=1. DWIDTH=64, lwu of 0xFFFF_FFFF -> 0x0000_0000_FFFF_FFFF.
- mem_req_ready low 5 cycles and rsp_ready low 3 cycles -> mem_addr and rsp_data stay stable; req_ready=0 throughout.
- rst asserted in WAIT0, then stray mem_rvalid -> IDLE, rsp_valid stays 0; next request completes normally.
